tdo_capture_monitor: RTL and testbench

- Bench-side receiver at the TDO end of the JTAG chain. Pairs with the TDI pattern generator.
- Serially captures TDO bits on TCK while the TAP is shifting and assembles them LSB-first into a parallel word.
- Compares the word against an expected pattern under a care mask and reports done and match status.
- Covers both boundary-scan register reads (BSC_Reg_size bits) and bypass reads (short lengths).

---
 rtl/tdo_capture_monitor.sv | 141 ++++++++++++++
 tb/tb_tdo_capture_monitor.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tdo_capture_monitor.sv
// tdo_capture_monitor
//
// Bench-side receiver at the TDO end of a JTAG chain, paired with the TDI
// pattern generator. While the TAP is shifting, TDO bits are captured LSB-first
// into a shift register. At the end of a scan the word is right-justified. It
// is then compared against an expected pattern under a care mask.
//
// Ports:
//   TCK              TAP clock; all state updates on its rising edge
//   reset            synchronous, active-high reset
//   from_TDO         serial data from the device TDO pin
//   shift_enable     qualifies from_TDO (TAP in Shift-DR/Shift-IR)
//   start            one-cycle pulse; arms a new capture (also aborts/re-arms)
//   length           bits to capture, 1..BSC_Reg_size (0 or too large -> max)
//   expected         expected pattern, right-justified
//   care_mask        1 = compare this bit
//   captured_pattern right-justified captured word, zero above length
//   bit_count        bits captured so far in the current scan
//   busy             high while shifting
//   done             one-cycle pulse when a capture completes
//   match            compare result, valid with done, held until next start
module tdo_capture_monitor #(
  parameter int unsigned BSC_Reg_size = 14,
  parameter int unsigned Count_size   = 4
) (
  input  logic                    TCK,
  input  logic                    reset,
  input  logic                    from_TDO,
  input  logic                    shift_enable,
  input  logic                    start,
  input  logic [Count_size-1:0]   length,
  input  logic [BSC_Reg_size-1:0] expected,
  input  logic [BSC_Reg_size-1:0] care_mask,
  output logic [BSC_Reg_size-1:0] captured_pattern,
  output logic [Count_size-1:0]   bit_count,
  output logic                    busy,
  output logic                    done,
  output logic                    match
);

  typedef enum logic [1:0] {StIdle, StShift, StComplete} state_e;

  localparam logic [Count_size-1:0] MaxLen = Count_size'(BSC_Reg_size);

  state_e                  state_q, state_d;
  logic [BSC_Reg_size-1:0] shift_q, shift_d;
  logic [BSC_Reg_size-1:0] cap_q, cap_d;
  logic [Count_size-1:0]   cnt_q, cnt_d;
  logic [Count_size-1:0]   len_q, len_d;
  logic [BSC_Reg_size-1:0] exp_q, exp_d;
  logic [BSC_Reg_size-1:0] mask_q, mask_d;
  logic                    done_q, done_d;
  logic                    match_q, match_d;

  logic [Count_size-1:0]   len_clamped;
  logic [Count_size-1:0]   cnt_inc;
  logic [BSC_Reg_size-1:0] justified;
  logic [BSC_Reg_size-1:0] low_mask;

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cap_d   = cap_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    exp_d   = exp_q;
    mask_d  = mask_q;
    done_d  = 1'b0;
    match_d = match_q;

    len_clamped = ((length == '0) || (length > MaxLen)) ? MaxLen : length;
    cnt_inc     = cnt_q + 1'b1;
    // Bits arrive at the top of the register, so a short scan sits in the
    // upper len_q bits; shifting down by the unused width right-justifies it.
    justified   = shift_q >> (MaxLen - len_q);
    // Shifting all-ones by the full width yields zero, so len_q = max gives
    // an all-ones mask.
    low_mask    = ~({BSC_Reg_size{1'b1}} << len_q);

    case (state_q)
      StIdle: ;
      StShift: begin
        if (shift_enable) begin
          shift_d = {from_TDO, shift_q[BSC_Reg_size-1:1]};
          cnt_d   = cnt_inc;
          if (cnt_inc == len_q) state_d = StComplete;
        end
      end
      StComplete: begin
        cap_d   = justified;
        match_d = (((justified ^ exp_q) & mask_q & low_mask) == '0);
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // start re-arms from any state. In StComplete the finishing scan still
    // reports its done/match; elsewhere match is cleared for the new scan.
    if (start) begin
      len_d   = len_clamped;
      exp_d   = expected;
      mask_d  = care_mask;
      shift_d = '0;
      cnt_d   = '0;
      state_d = StShift;
      if (state_q != StComplete) match_d = 1'b0;
    end
  end

  always_ff @(posedge TCK) begin
    if (reset) begin
      state_q <= StIdle;
      shift_q <= '0;
      cap_q   <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      exp_q   <= '0;
      mask_q  <= '0;
      done_q  <= 1'b0;
      match_q <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cap_q   <= cap_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      exp_q   <= exp_d;
      mask_q  <= mask_d;
      done_q  <= done_d;
      match_q <= match_d;
    end
  end

  assign captured_pattern = cap_q;
  assign bit_count        = cnt_q;
  assign busy             = (state_q == StShift);
  assign done             = done_q;
  assign match            = match_q;

endmodule

// File: tb/tb_tdo_capture_monitor.sv
module tb_tdo_capture_monitor;

  logic        TCK = 1'b0;
  logic        reset;
  logic        from_TDO;
  logic        shift_enable;
  logic        start;
  logic [3:0]  length;
  logic [13:0] expected;
  logic [13:0] care_mask;
  logic [13:0] captured_pattern;
  logic [3:0]  bit_count;
  logic        busy;
  logic        done;
  logic        match;

  int tests_run    = 0;
  int tests_failed = 0;

  tdo_capture_monitor #(
    .BSC_Reg_size(14),
    .Count_size  (4)
  ) dut (
    .TCK             (TCK),
    .reset           (reset),
    .from_TDO        (from_TDO),
    .shift_enable    (shift_enable),
    .start           (start),
    .length          (length),
    .expected        (expected),
    .care_mask       (care_mask),
    .captured_pattern(captured_pattern),
    .bit_count       (bit_count),
    .busy            (busy),
    .done            (done),
    .match           (match)
  );

  always #5 TCK = ~TCK;

  // Stimulus helpers only; comparisons live in the test tasks.
  task automatic arm(input logic [3:0] len, input logic [13:0] exp_v, input logic [13:0] mask);
    @(negedge TCK);
    start = 1'b1; length = len; expected = exp_v; care_mask = mask;
    @(negedge TCK);
    start = 1'b0;
  endtask

  task automatic send_bits(input logic [13:0] data, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge TCK);
      shift_enable = 1'b1;
      from_TDO     = data[i];
    end
  endtask

  // Drops shift_enable after the last bit and steps to just past the edge
  // where done should appear.
  task automatic to_done_edge();
    @(negedge TCK);
    shift_enable = 1'b0;
    from_TDO     = 1'b0;
    @(posedge TCK);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge TCK);
    #1;
    tests_run++;
    if ({busy, done, match} !== 3'b000) begin
      tests_failed++; $display("FAIL reset_flags: got %b want 000", {busy, done, match});
    end
    tests_run++;
    if (bit_count !== 4'd0 || captured_pattern !== 14'h0) begin
      tests_failed++;
      $display("FAIL reset_regs: got cnt=%0d cap=%h want 0/0", bit_count, captured_pattern);
    end
    @(negedge TCK);
    reset = 1'b0;
  endtask

  task automatic test_full_match();
    arm(4'd14, 14'h2A5C, 14'h3FFF);
    tests_run++;
    if (busy !== 1'b1) begin
      tests_failed++; $display("FAIL full_busy: got %b want 1", busy);
    end
    send_bits(14'h2A5C, 14);
    @(negedge TCK);
    shift_enable = 1'b0;
    // Last bit just captured: in COMPLETE, done not yet visible.
    tests_run++;
    if (done !== 1'b0 || busy !== 1'b0 || bit_count !== 4'd14) begin
      tests_failed++;
      $display("FAIL full_pre_done: got done=%b busy=%b cnt=%0d want 0/0/14",
               done, busy, bit_count);
    end
    @(posedge TCK);
    #1;
    tests_run++;
    if (done !== 1'b1 || captured_pattern !== 14'h2A5C || match !== 1'b1) begin
      tests_failed++;
      $display("FAIL full_done: got done=%b cap=%h match=%b want 1/2a5c/1",
               done, captured_pattern, match);
    end
    @(posedge TCK);
    #1;
    tests_run++;
    if (done !== 1'b0 || captured_pattern !== 14'h2A5C || match !== 1'b1 || bit_count !== 4'd14) begin
      tests_failed++;
      $display("FAIL full_hold: got done=%b cap=%h match=%b cnt=%0d want 0/2a5c/1/14",
               done, captured_pattern, match, bit_count);
    end
  endtask

  task automatic test_flip_and_mask();
    arm(4'd14, 14'h2A5C, 14'h3FFF);
    send_bits(14'h2ADC, 14);
    to_done_edge();
    tests_run++;
    if (done !== 1'b1 || captured_pattern !== 14'h2ADC || match !== 1'b0) begin
      tests_failed++;
      $display("FAIL flip: got done=%b cap=%h match=%b want 1/2adc/0",
               done, captured_pattern, match);
    end
    arm(4'd14, 14'h2A5C, 14'h3F7F);
    send_bits(14'h2ADC, 14);
    to_done_edge();
    tests_run++;
    if (done !== 1'b1 || captured_pattern !== 14'h2ADC || match !== 1'b1) begin
      tests_failed++;
      $display("FAIL masked: got done=%b cap=%h match=%b want 1/2adc/1",
               done, captured_pattern, match);
    end
  endtask

  task automatic test_bypass();
    arm(4'd1, 14'h0, 14'h3FFF);
    send_bits(14'h0, 1);
    to_done_edge();
    tests_run++;
    if (done !== 1'b1 || captured_pattern !== 14'h0 || match !== 1'b1 || bit_count !== 4'd1) begin
      tests_failed++;
      $display("FAIL bypass1: got done=%b cap=%h match=%b cnt=%0d want 1/0000/1/1",
               done, captured_pattern, match, bit_count);
    end
    arm(4'd4, 14'h000D, 14'h3FFF);
    send_bits(14'h000D, 4);
    to_done_edge();
    tests_run++;
    if (done !== 1'b1 || captured_pattern !== 14'h000D || match !== 1'b1) begin
      tests_failed++;
      $display("FAIL bypass4: got done=%b cap=%h match=%b want 1/000d/1",
               done, captured_pattern, match);
    end
  endtask

  task automatic test_gaps();
    logic [13:0] data;
    data = 14'h2A5C;
    arm(4'd14, 14'h2A5C, 14'h3FFF);
    for (int i = 0; i < 14; i++) begin
      if (i == 6) begin
        for (int g = 0; g < 3; g++) begin
          @(negedge TCK);
          shift_enable = 1'b0;
          from_TDO     = ~from_TDO;
          @(posedge TCK);
          #1;
          tests_run++;
          if (busy !== 1'b1 || bit_count !== 4'd6) begin
            tests_failed++;
            $display("FAIL gap_hold: got busy=%b cnt=%0d want 1/6", busy, bit_count);
          end
        end
      end
      @(negedge TCK);
      shift_enable = 1'b1;
      from_TDO     = data[i];
    end
    to_done_edge();
    tests_run++;
    if (done !== 1'b1 || captured_pattern !== 14'h2A5C || match !== 1'b1) begin
      tests_failed++;
      $display("FAIL gap_result: got done=%b cap=%h match=%b want 1/2a5c/1",
               done, captured_pattern, match);
    end
  endtask

  task automatic test_reset_midscan();
    arm(4'd14, 14'h2A5C, 14'h3FFF);
    send_bits(14'h2A5C, 6);
    @(negedge TCK);
    shift_enable = 1'b0;
    reset        = 1'b1;
    @(posedge TCK);
    #1;
    tests_run++;
    if (busy !== 1'b0 || bit_count !== 4'd0 || done !== 1'b0) begin
      tests_failed++;
      $display("FAIL midscan_reset: got busy=%b cnt=%0d done=%b want 0/0/0",
               busy, bit_count, done);
    end
    @(negedge TCK);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge TCK);
      #1;
      tests_run++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        tests_failed++;
        $display("FAIL midscan_quiet: got done=%b busy=%b want 0/0", done, busy);
      end
    end
  endtask

  task automatic test_restart();
    arm(4'd14, 14'h2A5C, 14'h3FFF);
    send_bits(14'h2A5C, 5);
    @(negedge TCK);
    shift_enable = 1'b0;
    arm(4'd8, 14'h00A5, 14'h3FFF);
    tests_run++;
    if (bit_count !== 4'd0 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL restart_clear: got cnt=%0d busy=%b want 0/1", bit_count, busy);
    end
    send_bits(14'h00A5, 7);
    @(negedge TCK);
    shift_enable = 1'b0;
    tests_run++;
    if (done !== 1'b0 || busy !== 1'b1 || bit_count !== 4'd7) begin
      tests_failed++;
      $display("FAIL restart_7: got done=%b busy=%b cnt=%0d want 0/1/7", done, busy, bit_count);
    end
    send_bits(14'h0001, 1);
    to_done_edge();
    tests_run++;
    if (done !== 1'b1 || captured_pattern !== 14'h00A5 || match !== 1'b1 || bit_count !== 4'd8) begin
      tests_failed++;
      $display("FAIL restart_done: got done=%b cap=%h match=%b cnt=%0d want 1/00a5/1/8",
               done, captured_pattern, match, bit_count);
    end
  endtask

  task automatic test_clamp();
    arm(4'd0, 14'h1234, 14'h3FFF);
    send_bits(14'h1234, 13);
    @(negedge TCK);
    shift_enable = 1'b0;
    @(posedge TCK);
    #1;
    tests_run++;
    if (done !== 1'b0 || busy !== 1'b1 || bit_count !== 4'd13) begin
      tests_failed++;
      $display("FAIL clamp_13: got done=%b busy=%b cnt=%0d want 0/1/13", done, busy, bit_count);
    end
    send_bits(14'h2000, 1);
    to_done_edge();
    tests_run++;
    if (done !== 1'b1 || captured_pattern !== 14'h1234 || match !== 1'b1 || bit_count !== 4'd14) begin
      tests_failed++;
      $display("FAIL clamp_done: got done=%b cap=%h match=%b cnt=%0d want 1/1234/1/14",
               done, captured_pattern, match, bit_count);
    end
  endtask

  task automatic test_back_to_back();
    arm(4'd2, 14'h0003, 14'h3FFF);
    send_bits(14'h0003, 2);
    // Now in COMPLETE; start here must still let the first scan report.
    @(negedge TCK);
    shift_enable = 1'b0;
    start = 1'b1; length = 4'd3; expected = 14'h0005; care_mask = 14'h3FFF;
    @(posedge TCK);
    #1;
    tests_run++;
    if (done !== 1'b1 || captured_pattern !== 14'h0003 || match !== 1'b1 ||
        busy !== 1'b1 || bit_count !== 4'd0) begin
      tests_failed++;
      $display("FAIL b2b_first: got done=%b cap=%h match=%b busy=%b cnt=%0d want 1/0003/1/1/0",
               done, captured_pattern, match, busy, bit_count);
    end
    @(negedge TCK);
    start = 1'b0;
    send_bits(14'h0005, 3);
    to_done_edge();
    tests_run++;
    if (done !== 1'b1 || captured_pattern !== 14'h0005 || match !== 1'b1) begin
      tests_failed++;
      $display("FAIL b2b_second: got done=%b cap=%h match=%b want 1/0005/1",
               done, captured_pattern, match);
    end
  endtask

  initial begin
    reset = 1'b1; from_TDO = 1'b0; shift_enable = 1'b0; start = 1'b0;
    length = 4'd0; expected = 14'h0; care_mask = 14'h0;
    test_reset();
    test_full_match();
    test_flip_and_mask();
    test_bypass();
    test_gaps();
    test_reset_midscan();
    test_restart();
    test_clamp();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
